// File: rtl/vc_alloc_if.sv
// Request/grant and release bundle between a VC requester and the vc_allocator.
interface vc_alloc_if #(
   parameter int NUM_VC = 8
);
   logic              alloc_req;
   logic [NUM_VC-1:0] release_mask;
   logic              alloc_gnt;
   logic [NUM_VC-1:0] alloc_vc;
   logic [NUM_VC-1:0] vc_busy;
   logic              all_busy;
   logic              release_err;

   modport master (
      output alloc_req,
      output release_mask,
      input  alloc_gnt,
      input  alloc_vc,
      input  vc_busy,
      input  all_busy,
      input  release_err
   );

   modport slave (
      input  alloc_req,
      input  release_mask,
      output alloc_gnt,
      output alloc_vc,
      output vc_busy,
      output all_busy,
      output release_err
   );
endinterface

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: one-cycle grant of a free VC, busy tracking and a sticky release-error flag.
// Define VC_ALLOC_RR_EN for round-robin selection; otherwise the lowest-index free VC wins.
module vc_allocator #(
   parameter int NUM_VC = 8
) (
   input logic      clk,
   input logic      rst_n,
   vc_alloc_if.slave bus
);

   logic [NUM_VC-1:0] busy_q;
   logic [NUM_VC-1:0] busy_d;
   logic [NUM_VC-1:0] pick;
   logic [NUM_VC-1:0] vc_q;
   logic              gnt_q;
   logic              err_q;
   logic              err_d;
   logic              take;
   logic              found;

`ifdef VC_ALLOC_RR_EN
   localparam int IDX_W = $clog2(NUM_VC);

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] sel_idx;

   // Scan starts at the pointer and wraps through the natural overflow of idx.
   always_comb begin
      pick    = '0;
      found   = 1'b0;
      idx     = '0;
      sel_idx = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         idx = ptr_q + IDX_W'(i);
         if (!found && !busy_q[idx]) begin
            pick[idx] = 1'b1;
            sel_idx   = idx;
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (take) begin
         ptr_d = sel_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (!found && !busy_q[i]) begin
            pick[i] = 1'b1;
            found   = 1'b1;
         end
      end
   end
`endif

   // A grant cycle blocks the next request, so grants come at most every other cycle.
   always_comb begin
      take   = bus.alloc_req && !gnt_q && found;
      busy_d = (busy_q & ~bus.release_mask) | (take ? pick : '0);
      err_d  = err_q | (|(bus.release_mask & ~busy_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         gnt_q  <= 1'b0;
         vc_q   <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         gnt_q  <= take;
         vc_q   <= take ? pick : '0;
         err_q  <= err_d;
      end
   end

   assign bus.alloc_gnt   = gnt_q;
   assign bus.alloc_vc    = vc_q;
   assign bus.vc_busy     = busy_q;
   assign bus.all_busy    = &busy_q;
   assign bus.release_err = err_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Self-checking bench for vc_allocator: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model of the allocation rules.
module tb_vc_allocator;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vc_alloc_if #(.NUM_VC(8)) bus ();

   vc_allocator #(.NUM_VC(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Behavioural model: the set of busy VCs, the pending grant and the search start point.
   bit m_busy [8];
   bit m_gnt  = 1'b0;
   int m_vc   = 0;
   bit m_err  = 1'b0;
   int m_ptr  = 0;

   function automatic logic [7:0] modelBusy();
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic resetModel();
      for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      m_gnt = 1'b0;
      m_vc  = 0;
      m_err = 1'b0;
      m_ptr = 0;
   endtask

   initial resetModel();
   always @(negedge rst_n) resetModel();

   always @(posedge clk) begin
      if (rst_n) begin
         int grant_idx;
         int start;
         grant_idx = -1;
`ifdef VC_ALLOC_RR_EN
         start = m_ptr;
`else
         start = 0;
`endif
         if (bus.alloc_req === 1'b1 && !m_gnt) begin
            for (int k = 0; k < 8; k++) begin
               if (grant_idx < 0 && !m_busy[(start + k) % 8]) grant_idx = (start + k) % 8;
            end
         end
         for (int i = 0; i < 8; i++) begin
            if (bus.release_mask[i]) begin
               if (m_busy[i]) m_busy[i] = 1'b0;
               else           m_err     = 1'b1;
            end
         end
         if (grant_idx >= 0) begin
            m_busy[grant_idx] = 1'b1;
            m_gnt = 1'b1;
            m_vc  = grant_idx;
            m_ptr = (grant_idx + 1) % 8;
         end else begin
            m_gnt = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 8'h%02h, required 8'h%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [7:0] exp_vc;
         exp_vc = '0;
         if (m_gnt) exp_vc[m_vc] = 1'b1;
         checkOutput("model alloc_gnt",   {7'd0, bus.alloc_gnt},   {7'd0, m_gnt});
         checkOutput("model alloc_vc",    bus.alloc_vc,            exp_vc);
         checkOutput("model vc_busy",     bus.vc_busy,             modelBusy());
         checkOutput("model all_busy",    {7'd0, bus.all_busy},    {7'd0, (modelBusy() == 8'hFF)});
         checkOutput("model release_err", {7'd0, bus.release_err}, {7'd0, m_err});
      end
   end

   task automatic waitGnt(input string name, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (bus.alloc_gnt === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s: alloc_gnt timeout, got 0, required 1", name);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.alloc_req    = 1'b0;
      bus.release_mask = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Random requester holds alloc_req until granted; releases mostly target busy VCs.
   task automatic applyStimulus();
      logic [7:0] rel;
      if (bus.alloc_gnt === 1'b1 || !bus.alloc_req)
         bus.alloc_req = ($urandom_range(0, 2) != 0);
      rel = 8'($urandom) & 8'($urandom) & modelBusy();
      if ($urandom_range(0, 3) != 0) rel = '0;
      if ($urandom_range(0, 40) == 0) rel[$urandom_range(0, 7)] = 1'b1;
      bus.release_mask = rel;
   endtask

   initial begin
      bit ok;
      logic [7:0] one_hot;
      bus.alloc_req    = 1'b0;
      bus.release_mask = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset alloc_gnt", {7'd0, bus.alloc_gnt}, 8'h00);
      checkOutput("reset vc_busy",   bus.vc_busy,           8'h00);
      rst_n = 1'b1;

      // Held request fills all VCs in index order on alternate cycles.
      bus.alloc_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         waitGnt("fill grant", ok);
         one_hot = 8'h01 << i;
         if (ok) checkOutput("fill alloc_vc", bus.alloc_vc, one_hot);
      end
      repeat (3) begin
         @(negedge clk);
         checkOutput("full no grant", {7'd0, bus.alloc_gnt}, 8'h00);
         checkOutput("full all_busy", {7'd0, bus.all_busy},  8'h01);
      end

      // Released VC becomes grantable only one edge after the release.
      bus.release_mask = 8'h04;
      @(negedge clk);
      bus.release_mask = 8'h00;
      checkOutput("release busy",       bus.vc_busy,           8'hFB);
      checkOutput("release no gnt yet", {7'd0, bus.alloc_gnt}, 8'h00);
      @(negedge clk);
      checkOutput("regrant gnt",  {7'd0, bus.alloc_gnt}, 8'h01);
      checkOutput("regrant vc",   bus.alloc_vc,          8'h04);
      bus.alloc_req = 1'b0;

      // Releasing an idle VC sets the sticky error without touching busy state.
      doReset();
      bus.release_mask = 8'h10;
      @(negedge clk);
      bus.release_mask = 8'h00;
      checkOutput("bad release busy", bus.vc_busy,             8'h00);
      checkOutput("bad release err",  {7'd0, bus.release_err}, 8'h01);
      repeat (3) @(negedge clk);
      checkOutput("err sticky", {7'd0, bus.release_err}, 8'h01);

      // Grant, release and re-request distinguishes round-robin from fixed priority.
      bus.alloc_req = 1'b1;
      waitGnt("pointer first", ok);
      if (ok) checkOutput("pointer first vc", bus.alloc_vc, 8'h01);
      bus.alloc_req    = 1'b0;
      bus.release_mask = 8'h01;
      @(negedge clk);
      bus.release_mask = 8'h00;
      bus.alloc_req    = 1'b1;
      waitGnt("pointer second", ok);
`ifdef VC_ALLOC_RR_EN
      if (ok) checkOutput("pointer second vc", bus.alloc_vc, 8'h02);
`else
      if (ok) checkOutput("pointer second vc", bus.alloc_vc, 8'h01);
`endif
      bus.alloc_req = 1'b0;

      // First grant coincides with a bad release; then reset asynchronously mid-grant.
      doReset();
      bus.alloc_req    = 1'b1;
      bus.release_mask = 8'h80;
      @(negedge clk);
      bus.release_mask = 8'h00;
      checkOutput("grant+bad rel vc",   bus.alloc_vc,            8'h01);
      checkOutput("grant+bad rel busy", bus.vc_busy,             8'h01);
      checkOutput("grant+bad rel err",  {7'd0, bus.release_err}, 8'h01);
      for (int i = 1; i < 6; i++) waitGnt("pre-reset grant", ok);
      checkOutput("pre-reset busy", bus.vc_busy, 8'h3F);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async rst gnt",  {7'd0, bus.alloc_gnt},   8'h00);
      checkOutput("async rst vc",   bus.alloc_vc,            8'h00);
      checkOutput("async rst busy", bus.vc_busy,             8'h00);
      checkOutput("async rst err",  {7'd0, bus.release_err}, 8'h00);
      bus.alloc_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with occasional mid-cycle resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!rst_n) rst_n = 1'b1;
         applyStimulus();
         if ($urandom_range(0, 400) == 0) begin
            #3;
            rst_n = 1'b0;
         end
      end
      @(negedge clk);
      bus.alloc_req    = 1'b0;
      bus.release_mask = '0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vc_allocator.md
VC_ALLOCATOR -- requirements
Module: vc_allocator

Interface
REQ-001 Parameter: NUM_VC, 8, number of virtual channels; width of every VC mask; fixed at 8 for this release.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: alloc_req  input  1  requester asks for one free VC; held high until alloc_gnt.
REQ-005 Port: release_mask  input  8  per-VC clear strobes from the VC cleaner path; bit i=1 frees VC i this cycle.
REQ-006 Port: alloc_gnt  output  1  registered one-cycle grant pulse.
REQ-007 Port: alloc_vc  output  8  one-hot granted VC; valid only while alloc_gnt=1, else 8'h00.
REQ-008 Port: vc_busy  output  8  registered busy state; bit i=1 means VC i is allocated.
REQ-009 Port: all_busy  output  1  high when vc_busy=8'hFF.
REQ-010 Port: release_err  output  1  sticky flag: release of a VC that was not busy.

Function
REQ-011 Grant latency SHALL be one cycle: alloc_req=1 and at least one vc_busy bit 0 at edge N gives alloc_gnt=1 and alloc_vc one-hot during cycle N+1.
REQ-012 Grant selection SHALL use only the vc_busy value present before edge N; a VC released at edge N is grantable no earlier than edge N+1.
REQ-013 On a grant, the granted bit of vc_busy SHALL be set at the same edge that raises alloc_gnt.
REQ-014 alloc_req SHALL be ignored in any cycle where alloc_gnt=1; maximum rate is one grant per two cycles.
REQ-015 alloc_req=1 with vc_busy=8'hFF SHALL produce no grant; the request waits and is granted at the first edge a free VC exists.
REQ-016 release_mask bit i with vc_busy[i]=1 SHALL clear vc_busy[i] at the next edge.
REQ-017 release_mask bit i with vc_busy[i]=0 SHALL leave vc_busy unchanged and set release_err=1 at the next edge; release_err stays 1 until reset.
REQ-018 Simultaneous grant of VC j and release of VC k (k!=j) SHALL both take effect at the same edge.
REQ-019 Multiple release_mask bits in one cycle SHALL all be honoured.
REQ-020 all_busy SHALL be combinational from the registered vc_busy.
REQ-021 alloc_gnt and alloc_vc SHALL return to 0 and 8'h00 the cycle after a grant.

Reset
REQ-022 rst_n=0 SHALL asynchronously force alloc_gnt=0, alloc_vc=8'h00, vc_busy=8'h00, release_err=0, and the priority pointer to 0.
REQ-023 A request pending when reset asserts SHALL be discarded; after deassertion it is re-evaluated only if alloc_req is still high.
REQ-024 Reset deassertion SHALL take effect at the first rising clk edge with rst_n=1.

Configuration
REQ-025 Macro VC_ALLOC_RR_EN defined: round-robin selection. The search for the first free VC starts at the pointer index and wraps 7->0. After each grant of VC j, the pointer becomes (j+1) mod 8.
REQ-026 Macro VC_ALLOC_RR_EN undefined: fixed priority. The lowest-index free VC is granted. The pointer logic SHALL not be instantiated.

Verification
REQ-027 Reset, then alloc_req=1 held -> grants VC0,1,2,...,7 (alloc_vc 8'h01..8'h80) on alternate cycles; then all_busy=1 and no further gnt.
REQ-028 All busy, req pending, release_mask=8'h04 at edge N -> vc_busy=8'hFB after edge N; gnt with alloc_vc=8'h04 in cycle N+2.
REQ-029 vc_busy=8'h00, release_mask=8'h10 -> vc_busy stays 8'h00; release_err=1 and remains 1 until rst_n=0.
REQ-030 RR_EN defined: grant VC0, release VC0, request again -> alloc_vc=8'h02. RR_EN undefined: same sequence -> alloc_vc=8'h01.
REQ-031 Pulse rst_n low mid-sequence with vc_busy=8'h3F and alloc_gnt=1 -> immediately vc_busy=8'h00, alloc_gnt=0, alloc_vc=8'h00, release_err=0, without a clock edge.
